mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master arbiter that shares the single external memory bus (the `ext_memInterface` CPU-side port) between the CPU (`nqcpu`) and a DMA requester. It uses the existing re/we/needWait handshake on both sides. Ownership is registered and locked for the duration of each transfer. Bandwidth is shared round-robin, and a granted master may run up to `MAX_BURST` back-to-back transfers while the other master waits. It sits between `cpu_inst`/DMA and `ext_memInterface_inst` in `soc`; the top level handles tristate conversion of `data_io`.

## Interface
- `MAX_BURST`, default 4. Maximum consecutive completed transfers per grant while the other master is requesting. Must be ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_addr_i`  in  24  CPU address.
- `cpu_re_i`, `cpu_we_i`  in  1 each  CPU read/write strobes.
- `cpu_data_i`  in  16  CPU write data.
- `cpu_data_o`  out  16  read data to CPU.
- `cpu_needWait_o`  out  1  CPU stall.
- `dma_addr_i`, `dma_re_i`, `dma_we_i`, `dma_data_i`, `dma_data_o`, `dma_needWait_o`  same as the CPU ports, for the DMA master.
- `mem_addr_o`  out  24  address to the memory interface.
- `mem_re_o`, `mem_we_o`  out  1 each  strobes to the memory interface.
- `mem_data_o`  out  16  write data to the memory interface.
- `mem_data_i`  in  16  read data from the memory interface.
- `mem_needWait_i`  in  1  memory-side stall.
- `owner_o`  out  2  debug: 00 idle, 01 CPU, 10 DMA.

## Operation
- Request: master X requests when `X_re_i | X_we_i`. A transfer completes at a rising edge where X owns the bus, X is requesting, and `mem_needWait_i`=0.
- Masters hold addr, data and strobes until completion.
- State register: IDLE, OWN_CPU, OWN_DMA.
- Additional registers:
  - `last` (last master to complete a transfer)
  - `cnt` (completed transfers in the current grant, width `$clog2(MAX_BURST+1)`, saturating at `MAX_BURST`)
- IDLE:
  - mem strobes 0.
  - One requester → OWN_that, `cnt`=0.
  - Both requesting → grant the master ≠ `last`.
  - No requester → stay in IDLE.
- OWN_X, bus signals:
  - `mem_*` driven from X's inputs.
  - If `X_we_i`=1, `mem_re_o` is forced to 0 (write wins when both strobes are high).
  - `X_needWait_o` = `mem_needWait_i`; `X_data_o` = `mem_data_i`.
- OWN_X, on completion edge:
  - `last`←X.
  - If the other master Y is requesting and `cnt`+1 ≥ `MAX_BURST` → OWN_Y directly, `cnt`←0.
  - Otherwise stay in OWN_X, `cnt`←`cnt`+1.
- OWN_X, when X is not requesting at an edge (no transfer in flight): Y requesting → OWN_Y, `cnt`←0; else → IDLE.
- The arbiter never changes owner while X is requesting and `mem_needWait_i`=1.
- Non-owner Y:
  - `Y_needWait_o` = `Y_re_i | Y_we_i`.
  - `Y_data_o` = 0.
- All master-facing and mem-facing outputs are combinational from the registered state plus current inputs. No data is registered.
- When IDLE, `mem_addr_o`=0 and `mem_data_o`=0.

## Timing
- Reset (asynchronous, immediate): state IDLE, `last`=DMA (CPU wins the first tie), `cnt`=0.
- Output values while `rst`=1:
  - `mem_re_o`=`mem_we_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `owner_o`=00.
  - Both `*_data_o`=0.
  - Each `*_needWait_o` equals that master's request.
- Reset during a transfer drops the mem strobes in the same cycle. The aborted transfer is not counted.
- Latency:
  - Request from IDLE: `needWait_o` is high for 1 arbitration cycle. The strobe appears on mem in the next cycle. With zero memory wait, completion is at the end of that cycle, so 2 cycles total.
  - Back-to-back transfers within a grant: 1 cycle each plus memory wait states.
  - Direct handover OWN_X→OWN_Y: Y's strobe reaches mem in the cycle after X completes. There is no IDLE bubble.
- Simultaneous new requests in IDLE: tie broken by `last`.
- If X and Y request continuously, they alternate grants of exactly `MAX_BURST` transfers each.
- `MAX_BURST`=1: strict alternation whenever both are requesting.

## Test plan
- Reset, then CPU read at addr 0x000010 with `mem_needWait_i`=0 → `cpu_needWait_o`=1 in cycle 0; in cycle 1, `mem_re_o`=1, `mem_addr_o`=0x000010, `owner_o`=01; `cpu_data_o`=`mem_data_i`=0xBEEF.
- CPU and DMA request together from reset → CPU is granted first. With both held continuously and `MAX_BURST`=4, the grant pattern is 4 CPU, 4 DMA, 4 CPU completions, with no idle cycles between grants.
- DMA owns the bus with `mem_needWait_i`=1 for 5 cycles while the CPU requests → owner stays 10 for all 5 cycles; `cpu_needWait_o`=1 throughout; the CPU is granted the cycle after DMA completion once `cnt` reaches 4, or immediately if DMA drops its request.
- CPU asserts `cpu_re_i`=`cpu_we_i`=1 with data 0x1234 → `mem_we_o`=1, `mem_re_o`=0, `mem_data_o`=0x1234.
- Assert `rst` mid-transfer (DMA owns, `mem_needWait_i`=1) → `mem_we_o`/`mem_re_o` go to 0 in the same cycle, `owner_o`=00; after release, a CPU/DMA tie goes to the CPU.
- `MAX_BURST`=1, both masters streaming writes → `owner_o` alternates 01/10 every completed transfer.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU/DMA) arbiter for the shared external memory bus.
// Registered ownership, round-robin tie-break and bounded bursts per grant.
module mem_bus_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cpu_addr_i,
  input  logic        cpu_re_i,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_data_i,
  output logic [15:0] cpu_data_o,
  output logic        cpu_needWait_o,
  input  logic [23:0] dma_addr_i,
  input  logic        dma_re_i,
  input  logic        dma_we_i,
  input  logic [15:0] dma_data_i,
  output logic [15:0] dma_data_o,
  output logic        dma_needWait_o,
  output logic [23:0] mem_addr_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic [15:0] mem_data_o,
  input  logic [15:0] mem_data_i,
  input  logic        mem_needWait_i,
  output logic [1:0]  owner_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    OWN_CPU = 2'b01,
    OWN_DMA = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;   // 1: DMA completed last
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic   cpu_req, dma_req;
  logic   own_req, oth_req;
  state_e oth_state;
  logic   burst_done;
  logic   own_cpu, own_dma;

  assign cpu_req    = cpu_re_i | cpu_we_i;
  assign dma_req    = dma_re_i | dma_we_i;
  assign own_req    = (state_q == OWN_CPU) ? cpu_req : dma_req;
  assign oth_req    = (state_q == OWN_CPU) ? dma_req : cpu_req;
  assign oth_state  = (state_q == OWN_CPU) ? OWN_DMA : OWN_CPU;
  // cnt never exceeds MAX_BURST, so cnt+1 >= MAX_BURST is cnt >= MAX_BURST-1
  assign burst_done = (cnt_q >= CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: ownership only moves on completion or when the owner goes quiet
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cpu_req && dma_req) begin
          state_d = last_q ? OWN_CPU : OWN_DMA;
        end else if (cpu_req) begin
          state_d = OWN_CPU;
        end else if (dma_req) begin
          state_d = OWN_DMA;
        end
      end
      OWN_CPU, OWN_DMA: begin
        if (own_req) begin
          if (!mem_needWait_i) begin
            last_d = (state_q == OWN_DMA);
            if (oth_req && burst_done) begin
              state_d = oth_state;
              cnt_d   = '0;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end else begin
          state_d = oth_req ? oth_state : IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset also gates ownership so strobes drop in the reset cycle itself
  assign own_cpu = (state_q == OWN_CPU) && !rst;
  assign own_dma = (state_q == OWN_DMA) && !rst;

  always_comb begin
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_re_o       = 1'b0;
    mem_we_o       = 1'b0;
    owner_o        = 2'b00;
    cpu_needWait_o = cpu_req;
    cpu_data_o     = '0;
    dma_needWait_o = dma_req;
    dma_data_o     = '0;
    if (own_cpu) begin
      mem_addr_o     = cpu_addr_i;
      mem_data_o     = cpu_data_i;
      mem_we_o       = cpu_we_i;
      mem_re_o       = cpu_re_i & ~cpu_we_i;
      owner_o        = 2'b01;
      cpu_needWait_o = mem_needWait_i;
      cpu_data_o     = mem_data_i;
    end else if (own_dma) begin
      mem_addr_o     = dma_addr_i;
      mem_data_o     = dma_data_i;
      mem_we_o       = dma_we_i;
      mem_re_o       = dma_re_i & ~dma_we_i;
      owner_o        = 2'b10;
      dma_needWait_o = mem_needWait_i;
      dma_data_o     = mem_data_i;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random masters, checked
// every cycle against a grant/burst model for MAX_BURST=4 and MAX_BURST=1.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_nw;
  logic [15:0] mem_rd;

  // [instance][master]: instance 0 has MAX_BURST=4, instance 1 MAX_BURST=1; master 0 CPU, 1 DMA
  logic        re_i   [2][2];
  logic        we_i   [2][2];
  logic [23:0] addr_i [2][2];
  logic [15:0] wd_i   [2][2];
  logic [15:0] rd_o   [2][2];
  logic        nw_o   [2][2];
  logic [23:0] maddr_o[2];
  logic        mre_o  [2];
  logic        mwe_o  [2];
  logic [15:0] mwd_o  [2];
  logic [1:0]  own_o  [2];

  int nvec = 0;
  int nerr = 0;
  bit run  = 0;

  // model: owner 0 idle / 1 CPU / 2 DMA; last master to complete; transfers in this grant
  int m_own [2] = '{0, 0};
  int m_last[2] = '{2, 2};
  int m_cnt [2] = '{0, 0};
  bit m_done[2][2];

  int pat[12] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1, 1, 1};

  always #5 clk = ~clk;

  mem_bus_arbiter #(.MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .cpu_addr_i(addr_i[0][0]), .cpu_re_i(re_i[0][0]), .cpu_we_i(we_i[0][0]),
    .cpu_data_i(wd_i[0][0]), .cpu_data_o(rd_o[0][0]), .cpu_needWait_o(nw_o[0][0]),
    .dma_addr_i(addr_i[0][1]), .dma_re_i(re_i[0][1]), .dma_we_i(we_i[0][1]),
    .dma_data_i(wd_i[0][1]), .dma_data_o(rd_o[0][1]), .dma_needWait_o(nw_o[0][1]),
    .mem_addr_o(maddr_o[0]), .mem_re_o(mre_o[0]), .mem_we_o(mwe_o[0]),
    .mem_data_o(mwd_o[0]), .mem_data_i(mem_rd), .mem_needWait_i(mem_nw),
    .owner_o(own_o[0])
  );

  mem_bus_arbiter #(.MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_addr_i(addr_i[1][0]), .cpu_re_i(re_i[1][0]), .cpu_we_i(we_i[1][0]),
    .cpu_data_i(wd_i[1][0]), .cpu_data_o(rd_o[1][0]), .cpu_needWait_o(nw_o[1][0]),
    .dma_addr_i(addr_i[1][1]), .dma_re_i(re_i[1][1]), .dma_we_i(we_i[1][1]),
    .dma_data_i(wd_i[1][1]), .dma_data_o(rd_o[1][1]), .dma_needWait_o(nw_o[1][1]),
    .mem_addr_o(maddr_o[1]), .mem_re_o(mre_o[1]), .mem_we_o(mwe_o[1]),
    .mem_data_o(mwd_o[1]), .mem_data_i(mem_rd), .mem_needWait_i(mem_nw),
    .owner_o(own_o[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // One clock edge of the model for instance k
  task automatic model_edge(input int k);
    int burst;
    int x;
    int y;
    bit rq[2];
    burst = (k == 0) ? 4 : 1;
    for (int m = 0; m < 2; m++) rq[m] = re_i[k][m] | we_i[k][m];
    if (m_own[k] == 0) begin
      if (rq[0] && rq[1]) m_own[k] = (m_last[k] == 1) ? 2 : 1;
      else if (rq[0])     m_own[k] = 1;
      else if (rq[1])     m_own[k] = 2;
      m_cnt[k] = 0;
    end else begin
      x = m_own[k] - 1;
      y = 1 - x;
      if (!rq[x]) begin
        m_own[k] = rq[y] ? y + 1 : 0;
        m_cnt[k] = 0;
      end else if (!mem_nw) begin
        m_done[k][x] = 1;
        m_last[k]    = m_own[k];
        if (rq[y] && m_cnt[k] + 1 >= burst) begin
          m_own[k] = y + 1;
          m_cnt[k] = 0;
        end else begin
          m_cnt[k] = (m_cnt[k] + 1 > burst) ? burst : m_cnt[k] + 1;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      m_done[k][0] = 0;
      m_done[k][1] = 0;
      if (rst) begin
        m_own[k]  = 0;
        m_last[k] = 2;
        m_cnt[k]  = 0;
      end else begin
        model_edge(k);
      end
    end
  end

  task automatic check_outputs(input int k);
    int x;
    logic        e_re, e_we, e_nw;
    logic [23:0] e_addr;
    logic [15:0] e_wd, e_rd;
    e_re = 0; e_we = 0; e_addr = '0; e_wd = '0;
    if (m_own[k] != 0) begin
      x      = m_own[k] - 1;
      e_we   = we_i[k][x];
      e_re   = re_i[k][x] & ~we_i[k][x];
      e_addr = addr_i[k][x];
      e_wd   = wd_i[k][x];
    end
    chk("mem_re_o",   k, 32'(mre_o[k]),   32'(e_re));
    chk("mem_we_o",   k, 32'(mwe_o[k]),   32'(e_we));
    chk("mem_addr_o", k, 32'(maddr_o[k]), 32'(e_addr));
    chk("mem_data_o", k, 32'(mwd_o[k]),   32'(e_wd));
    chk("owner_o",    k, 32'(own_o[k]),   32'(m_own[k]));
    for (int m = 0; m < 2; m++) begin
      e_nw = (m_own[k] == m + 1) ? mem_nw : (re_i[k][m] | we_i[k][m]);
      e_rd = (m_own[k] == m + 1) ? mem_rd : 16'h0;
      chk(m == 0 ? "cpu_needWait_o" : "dma_needWait_o", k, 32'(nw_o[k][m]), 32'(e_nw));
      chk(m == 0 ? "cpu_data_o" : "dma_data_o",         k, 32'(rd_o[k][m]), 32'(e_rd));
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      for (int k = 0; k < 2; k++) check_outputs(k);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        re_i[k][m] = 0; we_i[k][m] = 0; addr_i[k][m] = '0; wd_i[k][m] = '0;
      end
    end
    mem_nw = 0;
    mem_rd = '0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic new_txn(input int k, input int m);
    int kind;
    kind = $urandom_range(0, 2);
    re_i[k][m]   = (kind != 1);
    we_i[k][m]   = (kind != 0);
    addr_i[k][m] = 24'($urandom);
    wd_i[k][m]   = 16'($urandom);
  endtask

  initial begin
    do_reset();
    run = 1;

    // CPU read from IDLE: one arbitration cycle, then the strobe on mem
    re_i[0][0] = 1; addr_i[0][0] = 24'h000010; mem_rd = 16'hBEEF;
    @(negedge clk);
    chk("t1_cpu_nw_arb", 0, 32'(nw_o[0][0]), 32'd1);
    chk("t1_owner_arb",  0, 32'(own_o[0]),   32'd0);
    tick();
    @(negedge clk);
    chk("t1_mem_re",   0, 32'(mre_o[0]),   32'd1);
    chk("t1_mem_addr", 0, 32'(maddr_o[0]), 32'h10);
    chk("t1_owner",    0, 32'(own_o[0]),   32'd1);
    chk("t1_cpu_data", 0, 32'(rd_o[0][0]), 32'hBEEF);
    tick();

    // Tie from reset: CPU first, then bursts of 4 alternate with no idle gap
    do_reset();
    re_i[0][0] = 1; re_i[0][1] = 1;
    @(negedge clk);
    chk("t2_owner_arb", 0, 32'(own_o[0]), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      @(negedge clk);
      chk("t2_burst_owner", 0, 32'(own_o[0]), 32'(pat[i]));
    end
    tick();

    // DMA stalled by memory keeps the bus; CPU waits throughout
    do_reset();
    we_i[0][1] = 1; addr_i[0][1] = 24'h00ABCD; wd_i[0][1] = 16'h5A5A;
    tick();
    mem_nw = 1; re_i[0][0] = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_owner_stall", 0, 32'(own_o[0]),   32'd2);
      chk("t3_cpu_nw",      0, 32'(nw_o[0][0]), 32'd1);
      tick();
    end
    mem_nw = 0;
    tick();
    we_i[0][1] = 0;
    @(negedge clk);
    chk("t3_owner_after_1", 0, 32'(own_o[0]), 32'd2);
    tick();
    @(negedge clk);
    chk("t3_owner_handover", 0, 32'(own_o[0]), 32'd1);
    tick();

    // Both strobes high: write wins
    do_reset();
    re_i[0][0] = 1; we_i[0][0] = 1; wd_i[0][0] = 16'h1234; mem_nw = 1;
    tick();
    @(negedge clk);
    chk("t4_mem_we",   0, 32'(mwe_o[0]), 32'd1);
    chk("t4_mem_re",   0, 32'(mre_o[0]), 32'd0);
    chk("t4_mem_data", 0, 32'(mwd_o[0]), 32'h1234);
    tick();

    // Reset in the middle of a stalled DMA write
    do_reset();
    we_i[0][1] = 1; addr_i[0][1] = 24'h000400; mem_nw = 1;
    tick();
    @(negedge clk);
    chk("t5_mem_we_pre", 0, 32'(mwe_o[0]), 32'd1);
    #2 rst = 1;
    #1;
    chk("t5_mem_we_rst", 0, 32'(mwe_o[0]),   32'd0);
    chk("t5_mem_re_rst", 0, 32'(mre_o[0]),   32'd0);
    chk("t5_owner_rst",  0, 32'(own_o[0]),   32'd0);
    chk("t5_dma_nw_rst", 0, 32'(nw_o[0][1]), 32'd1);
    tick();
    rst = 0;
    we_i[0][1] = 0; re_i[0][1] = 1; re_i[0][0] = 1; mem_nw = 0;
    @(negedge clk);
    chk("t5_owner_idle", 0, 32'(own_o[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_tie_cpu", 0, 32'(own_o[0]), 32'd1);
    tick();

    // MAX_BURST=1: owner alternates every completed transfer
    do_reset();
    we_i[1][0] = 1; we_i[1][1] = 1;
    @(negedge clk);
    chk("t6_owner_arb", 1, 32'(own_o[1]), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      chk("t6_alternate", 1, 32'(own_o[1]), (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    tick();

    // Random masters that hold each transfer until the model sees it complete
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (rst) rst = 0;
      else if ($urandom_range(0, 299) == 0) rst = 1;
      mem_nw = ($urandom_range(0, 99) < 35);
      mem_rd = 16'($urandom);
      for (int k = 0; k < 2; k++) begin
        for (int m = 0; m < 2; m++) begin
          if (re_i[k][m] | we_i[k][m]) begin
            if (m_done[k][m]) begin
              if ($urandom_range(0, 9) < 7) new_txn(k, m);
              else begin re_i[k][m] = 0; we_i[k][m] = 0; end
            end
          end else if ($urandom_range(0, 9) < 4) begin
            new_txn(k, m);
          end
        end
      end
      tick();
    end

    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
